spi_counter_rx: RTL and testbench

SPI slave receiver sitting directly downstream of `master_top`. It samples `sclk`/`mosi`/`ss` in the local 100 MHz clock domain (SPI mode 0, MSB first), reassembles each two-byte frame into the 14-bit counter value and presents it as a registered output with a one-cycle valid strobe. It feeds the display/consumer logic on the receiving board. Optionally it echoes the last committed value back on `miso` so the master can read it back.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_counter_rx_if.sv | 11 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_counter_rx.sv | 124 ++++++++++++
 tb/tb_spi_counter_rx.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI counter receiver.
`timescale 1ns/1ps
package spi_pkg;
    localparam int SPI_FRAME_BITS = 16;
    localparam int SPI_BIT_CNT_W  = 5;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} spi_rx_state_e;
endpackage

// File: rtl/spi_counter_rx_if.sv
// SPI bus lines between master_top and spi_counter_rx.
`timescale 1ns/1ps
interface spi_counter_rx_if;
    logic sclk;
    logic mosi;
    logic ss;
    logic miso;

    modport master (output sclk, output mosi, output ss, input miso);
    modport slave  (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input, plus a history flop for edge detection.
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = o_level & ~hist_q;
    assign o_fall  = ~o_level & hist_q;
endmodule

// File: rtl/spi_counter_rx.sv
// SPI mode-0 slave that reassembles 16-bit frames into a counter value with valid/error strobes.
// Define SPI_COUNTER_RX_MISO_EN to echo the last committed counter on miso.
`timescale 1ns/1ps
module spi_counter_rx
    import spi_pkg::*;
#(
    parameter int COUNTER_W   = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_counter_rx_if.slave      spi,
    output logic [COUNTER_W-1:0] o_counter,
    output logic                 o_valid,
    output logic                 o_frame_err
);
    localparam logic [SPI_BIT_CNT_W-1:0] FULL_CNT = SPI_BIT_CNT_W'(SPI_FRAME_BITS);
    localparam logic [SPI_BIT_CNT_W-1:0] SAT_CNT  = SPI_BIT_CNT_W'(SPI_FRAME_BITS + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic ss_level, ss_rise, ss_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(spi.sclk),
        .o_level(sclk_level), .o_rise(sclk_rise), .o_fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(spi.mosi),
        .o_level(mosi_level), .o_rise(mosi_rise), .o_fall(mosi_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .reset(reset), .din(spi.ss),
        .o_level(ss_level), .o_rise(ss_rise), .o_fall(ss_fall)
    );

    spi_rx_state_e                state_q, state_d;
    logic [SPI_FRAME_BITS-1:0]    rx_q;
    logic [SPI_BIT_CNT_W-1:0]     bit_cnt_q;
    logic start, shift_in, shift_out, accept, reject;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // An ss rise takes priority; sclk edges in that same cycle are dropped.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = CHECK;
                end else begin
                    shift_in  = sclk_rise;
                    shift_out = sclk_fall;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (bit_cnt_q == FULL_CNT && (rx_q >> COUNTER_W) == '0) accept = 1'b1;
                else                                                    reject = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            o_counter   <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= accept;
            o_frame_err <= reject;
            if (start) begin
                bit_cnt_q <= '0;
            end else if (shift_in) begin
                rx_q <= {rx_q[SPI_FRAME_BITS-2:0], mosi_level};
                if (bit_cnt_q != SAT_CNT) bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (accept) o_counter <= rx_q[COUNTER_W-1:0];
        end
    end

`ifdef SPI_COUNTER_RX_MISO_EN
    logic [SPI_FRAME_BITS-1:0] tx_q;
    logic                      miso_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
        end else begin
            if (start)          tx_q <= SPI_FRAME_BITS'(o_counter);
            else if (shift_out) tx_q <= {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
            miso_q <= tx_q[SPI_FRAME_BITS-1];
        end
    end

    assign spi.miso = miso_q;

    logic unused_edges;
    assign unused_edges = ^{sclk_level, mosi_rise, mosi_fall, ss_level};
`else
    assign spi.miso = 1'b0;

    logic unused_edges;
    assign unused_edges = ^{sclk_level, sclk_fall, mosi_rise, mosi_fall, ss_level};
`endif
endmodule

// File: tb/tb_spi_counter_rx.sv
// Directed self-checking bench for spi_counter_rx (5 MHz SCLK against a 100 MHz clk).
`timescale 1ns/1ps
module tb_spi_counter_rx;
    localparam int HALF = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] o_counter;
    logic        o_valid;
    logic        o_frame_err;

    int tests = 0;
    int failed = 0;
    int valid_total = 0;
    int err_total = 0;
    int both_total = 0;

    spi_counter_rx_if spi ();

    spi_counter_rx #(.COUNTER_W(14), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi(spi),
        .o_counter(o_counter), .o_valid(o_valid), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) valid_total++;
        if (o_frame_err) err_total++;
        if (o_valid && o_frame_err) both_total++;
    end

    // Shifts the n MSBs of d out in mode 0; miso is captured just before each rising edge.
    task automatic send_bits(input logic [15:0] d, input int n, output logic [15:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            spi.mosi = d[15-i];
            #HALF;
            cap[15-i] = spi.miso;
            spi.sclk = 1'b1;
            #HALF;
            spi.sclk = 1'b0;
        end
        #HALF;
    endtask

    task automatic send_frame(input logic [15:0] d, output logic [15:0] cap);
        spi.ss = 1'b0;
        send_bits(d, 16, cap);
        spi.ss = 1'b1;
        #200;
    endtask

    task automatic test_reset;
        spi.sclk = 1'b0; spi.mosi = 1'b0; spi.ss = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (o_counter !== 14'h0) begin failed++; $display("FAIL reset_counter: got %h expected 0000", o_counter); end
        tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        tests++; if (o_frame_err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b expected 0", o_frame_err); end
        tests++; if (spi.miso !== 1'b0) begin failed++; $display("FAIL reset_miso: got %b expected 0", spi.miso); end
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #2;
    endtask

    task automatic test_frame;
        int v0, e0;
        logic [15:0] cap;
        logic [3:0] vseq;
        logic [13:0] cnt3, cnt4;
        v0 = valid_total; e0 = err_total;
        spi.ss = 1'b0;
        send_bits(16'h1234, 16, cap);
        @(posedge clk); #2;
        spi.ss = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            vseq[k] = o_valid;
            if (k == 2) cnt3 = o_counter;
            if (k == 3) cnt4 = o_counter;
        end
        #200;
        tests++; if (vseq !== 4'b1000) begin failed++; $display("FAIL frame_valid_timing: got %b expected 1000", vseq); end
        tests++; if (cnt3 !== 14'h0) begin failed++; $display("FAIL frame_counter_before: got %h expected 0000", cnt3); end
        tests++; if (cnt4 !== 14'h1234) begin failed++; $display("FAIL frame_counter_edge: got %h expected 1234", cnt4); end
        tests++; if (valid_total - v0 !== 1) begin failed++; $display("FAIL frame_valid_count: got %0d expected 1", valid_total - v0); end
        tests++; if (err_total - e0 !== 0) begin failed++; $display("FAIL frame_err_count: got %0d expected 0", err_total - e0); end
    endtask

    task automatic test_short_frame;
        int v0, e0;
        logic [15:0] cap;
        v0 = valid_total; e0 = err_total;
        spi.ss = 1'b0;
        send_bits(16'h3F00, 8, cap);
        spi.ss = 1'b1;
        #200;
        tests++; if (err_total - e0 !== 1) begin failed++; $display("FAIL short_err_count: got %0d expected 1", err_total - e0); end
        tests++; if (valid_total - v0 !== 0) begin failed++; $display("FAIL short_valid_count: got %0d expected 0", valid_total - v0); end
        tests++; if (o_counter !== 14'h1234) begin failed++; $display("FAIL short_counter: got %h expected 1234", o_counter); end
    endtask

    task automatic test_pad_error;
        int v0, e0;
        logic [15:0] cap;
        v0 = valid_total; e0 = err_total;
        send_frame(16'hC001, cap);
        tests++; if (err_total - e0 !== 1) begin failed++; $display("FAIL pad_err_count: got %0d expected 1", err_total - e0); end
        tests++; if (valid_total - v0 !== 0) begin failed++; $display("FAIL pad_valid_count: got %0d expected 0", valid_total - v0); end
        tests++; if (o_counter !== 14'h1234) begin failed++; $display("FAIL pad_counter: got %h expected 1234", o_counter); end
    endtask

    task automatic test_reset_mid_frame;
        int v0, e0;
        logic [15:0] cap;
        spi.ss = 1'b0;
        send_bits(16'h0005, 9, cap);
        reset = 1'b0;
        #1;
        tests++; if (o_counter !== 14'h0) begin failed++; $display("FAIL midrst_counter: got %h expected 0000", o_counter); end
        tests++; if (o_valid !== 1'b0 || o_frame_err !== 1'b0) begin failed++; $display("FAIL midrst_strobes: got %b%b expected 00", o_valid, o_frame_err); end
        #29;
        reset = 1'b1;
        v0 = valid_total; e0 = err_total;
        send_bits(16'h0A00, 7, cap);
        spi.ss = 1'b1;
        #200;
        tests++; if (valid_total - v0 !== 0 || err_total - e0 !== 0) begin
            failed++; $display("FAIL midrst_orphan: got valid %0d err %0d expected 0 0", valid_total - v0, err_total - e0);
        end
        v0 = valid_total;
        send_frame(16'h0007, cap);
        tests++; if (o_counter !== 14'h0007) begin failed++; $display("FAIL midrst_next_counter: got %h expected 0007", o_counter); end
        tests++; if (valid_total - v0 !== 1) begin failed++; $display("FAIL midrst_next_valid: got %0d expected 1", valid_total - v0); end
    endtask

    task automatic test_miso;
        logic [15:0] cap;
        send_frame(16'h2ABC, cap);
        tests++; if (o_counter !== 14'h2ABC) begin failed++; $display("FAIL miso_commit: got %h expected 2abc", o_counter); end
        send_frame(16'h0000, cap);
`ifdef SPI_COUNTER_RX_MISO_EN
        tests++; if (cap !== 16'h2ABC) begin failed++; $display("FAIL miso_echo: got %h expected 2abc", cap); end
`else
        tests++; if (cap !== 16'h0000) begin failed++; $display("FAIL miso_tied: got %h expected 0000", cap); end
`endif
        tests++; if (o_counter !== 14'h0000) begin failed++; $display("FAIL miso_zero_frame: got %h expected 0000", o_counter); end
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        logic [15:0] cap;
        v0 = valid_total; e0 = err_total;
        spi.ss = 1'b0;
        send_bits(16'h0001, 16, cap);
        spi.ss = 1'b1;
        #40;
        spi.ss = 1'b0;
        send_bits(16'h0002, 16, cap);
        spi.ss = 1'b1;
        #200;
        tests++; if (valid_total - v0 !== 2) begin failed++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_total - v0); end
        tests++; if (err_total - e0 !== 0) begin failed++; $display("FAIL b2b_err_count: got %0d expected 0", err_total - e0); end
        tests++; if (o_counter !== 14'h0002) begin failed++; $display("FAIL b2b_counter: got %h expected 0002", o_counter); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_short_frame();
        test_pad_error();
        test_reset_mid_frame();
        test_miso();
        test_back_to_back();
        tests++; if (both_total !== 0) begin failed++; $display("FAIL strobe_overlap: got %0d expected 0", both_total); end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
